// File: rtl/nanci_edge_tx.sv
// Mesh edge transmitter: buffers {addr,data} words in a small FIFO and plays them onto
// one neighbour link, holding each word for HOLD_CYCLES cycles and padding with MAX_INT.
module nanci_edge_tx #(
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned DATA_WIDTH  = 3,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = {(ADDR_WIDTH+DATA_WIDTH){1'b1}},
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic                             i_start,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [CNT_WIDTH-1:0]             o_sent
);

  localparam int unsigned WordW = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e               state_q, state_d;
  logic [WordW-1:0]     mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic [WordW-1:0]     pe_q, pe_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic                 push, pop;
  logic                 empty;

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
  assign o_ready = (count_q != CntW'(DEPTH));
  assign push    = i_valid && o_ready;
  assign empty   = (count_q == '0);

  assign o_PE   = pe_q;
  assign o_busy = (state_q == StSend);
  assign o_done = done_q;
  assign o_sent = sent_q;

  // FIFO storage; contents are don't-care after reset since pointers and count clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_addr, i_data};
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM: load head on start, hold each word, then chain or pad and finish.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pe_d    = pe_q;
    done_d  = 1'b0;
    sent_d  = sent_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        pe_d = MAX_INT;
        if (i_start) begin
          if (!empty) begin
            pe_d    = mem_q[rd_ptr_q];
            pop     = 1'b1;
            hold_d  = HoldInit;
            sent_d  = sent_q + CNT_WIDTH'(1);
            state_d = StSend;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StSend: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HoldW'(1);
        end else if (!empty) begin
          pe_d   = mem_q[rd_ptr_q];
          pop    = 1'b1;
          hold_d = HoldInit;
          sent_d = sent_q + CNT_WIDTH'(1);
        end else begin
          pe_d    = MAX_INT;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset also drops any buffered words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      pe_q     <= MAX_INT;
      done_q   <= 1'b0;
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      pe_q     <= pe_d;
      done_q   <= done_d;
      sent_q   <= sent_d;
    end
  end

endmodule

// File: tb/tb_nanci_edge_tx.sv
// Scoreboard bench for nanci_edge_tx: stimulus queues expected link words and done events,
// a negedge monitor pops and compares whenever the DUT is busy or pulses done.
module tb_nanci_edge_tx;

  localparam logic [5:0] MaxW = 6'b111_111;

  logic       clk;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [2:0] i_addr;
  logic [2:0] i_data;
  logic       i_start;
  logic [5:0] o_PE;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_sent;

  int n_vec = 0;
  int n_err = 0;

  logic [5:0] exp_pe[$];
  int         exp_done[$];

  nanci_edge_tx dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_addr  (i_addr),
    .i_data  (i_data),
    .i_start (i_start),
    .o_PE    (o_PE),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sent  (o_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every busy cycle consumes one expected link word; every done pulse one event.
  always @(negedge clk) begin
    if (rst) begin
      if (o_busy) begin
        if (exp_pe.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_busy: got o_PE=%0d expected idle at %0t", o_PE, $time);
        end else begin
          check("link_word", int'(o_PE), int'(exp_pe.pop_front()));
        end
      end
      if (o_done) begin
        if (exp_done.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got o_done=1 expected 0 at %0t", $time);
        end else begin
          check("done_sent", int'(o_sent), exp_done.pop_front());
          check("done_pe_pad", int'(o_PE), int'(MaxW));
          check("done_not_busy", int'(o_busy), 0);
          if (exp_pe.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL early_done: got done with %0d words pending expected 0", exp_pe.size());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic push_word(input logic [5:0] w);
    i_valid = 1'b1;
    {i_addr, i_data} = w;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic expect_word(input logic [5:0] w);
    exp_pe.push_back(w);
    exp_pe.push_back(w);
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 50; i++) begin
      if (exp_pe.size() == 0 && exp_done.size() == 0) break;
      tick();
    end
    check({name, "_drained"}, exp_pe.size() + exp_done.size(), 0);
    tick();
  endtask

  initial begin
    rst     = 1'b0;
    i_valid = 1'b0;
    i_addr  = '0;
    i_data  = '0;
    i_start = 1'b0;
    tick();
    tick();
    check("rst_pe", int'(o_PE), int'(MaxW));
    check("rst_ready", int'(o_ready), 1);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_sent", int'(o_sent), 0);
    rst = 1'b1;
    tick();

    // Single word held two cycles, then pad with done.
    push_word(6'b000_100);
    expect_word(6'b000_100);
    exp_done.push_back(1);
    start();
    wait_drain("single");
    check("single_sent", int'(o_sent), 1);

    // Fill to depth, fifth push dropped.
    reset_dut();
    for (int k = 1; k <= 5; k++) begin
      push_word(6'(k));
      check($sformatf("fill_ready_%0d", k), int'(o_ready), (k >= 4) ? 0 : 1);
    end
    for (int k = 1; k <= 4; k++) expect_word(6'(k));
    exp_done.push_back(4);
    start();
    wait_drain("fill");
    check("fill_ready_after", int'(o_ready), 1);

    // Empty start: done only, link stays padded.
    reset_dut();
    exp_done.push_back(0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("empty_busy", int'(o_busy), 0);
    check("empty_pe", int'(o_PE), int'(MaxW));
    wait_drain("empty");

    // Push during SEND chains without a gap.
    reset_dut();
    push_word(6'd7);
    expect_word(6'd7);
    expect_word(6'd9);
    exp_done.push_back(2);
    start();
    push_word(6'd9);
    wait_drain("chain");

    // Asynchronous reset in the middle of the second word.
    reset_dut();
    push_word(6'd10);
    push_word(6'd11);
    push_word(6'd12);
    expect_word(6'd10);
    expect_word(6'd11);
    expect_word(6'd12);
    exp_done.push_back(3);
    start();
    tick();
    tick();
    check("mid_pe_before", int'(o_PE), 11);
    rst = 1'b0;
    #1;
    check("mid_pe", int'(o_PE), int'(MaxW));
    check("mid_sent", int'(o_sent), 0);
    check("mid_ready", int'(o_ready), 1);
    check("mid_busy", int'(o_busy), 0);
    exp_pe.delete();
    exp_done.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp_done.push_back(0);
    start();
    wait_drain("post_reset");
    check("post_reset_pe", int'(o_PE), int'(MaxW));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
